// File: rtl/relay_pkg.sv
// Shared types and constants for the relay-computer switching elements.
package relay_pkg;
   localparam int RELAY_CNT_W = 8;
   localparam int RELAY_POLES = 4;

   typedef enum logic [1:0] {RELEASED, PULLING, ENERGIZED, DROPPING} relay_state_t;
endpackage

// File: rtl/relay_4pdt_if.sv
// Coil drive, pole commons and contact outputs of one 4PDT relay.
interface relay_4pdt_if;
   logic control;
   logic in_0, in_1, in_2, in_3;
   logic out_hi_0, out_hi_1, out_hi_2, out_hi_3;
   logic out_lo_0, out_lo_1, out_lo_2, out_lo_3;
   logic energized;

   modport master (
      output control, in_0, in_1, in_2, in_3,
      input  out_hi_0, out_hi_1, out_hi_2, out_hi_3,
      input  out_lo_0, out_lo_1, out_lo_2, out_lo_3, energized
   );

   modport slave (
      input  control, in_0, in_1, in_2, in_3,
      output out_hi_0, out_hi_1, out_hi_2, out_hi_3,
      output out_lo_0, out_lo_1, out_lo_2, out_lo_3, energized
   );
endinterface

// File: rtl/relay_pole.sv
// One relay pole: the common passes only through a closed contact; open contacts drive 0.
module relay_pole (
   input  logic i_in,
   input  logic i_closed_hi,
   input  logic i_closed_lo,
   output logic o_out_hi,
   output logic o_out_lo
);
   assign o_out_hi = i_in & i_closed_hi;
   assign o_out_lo = i_in & i_closed_lo;
endmodule

// File: rtl/relay_4pdt.sv
// Four-pole double-throw relay with pull-in/drop-out open windows (break-before-make).
module relay_4pdt
   import relay_pkg::*;
#(
   parameter int PULL_IN_CYCLES  = 1,
   parameter int DROP_OUT_CYCLES = 1
) (
   input logic         clk,
   input logic         reset,
   relay_4pdt_if.slave bus
);
   localparam logic [RELAY_CNT_W-1:0] PULL_LD = PULL_IN_CYCLES[RELAY_CNT_W-1:0];
   localparam logic [RELAY_CNT_W-1:0] DROP_LD = DROP_OUT_CYCLES[RELAY_CNT_W-1:0];

   relay_state_t           r_state, w_state_nxt;
   logic [RELAY_CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [RELAY_POLES-1:0] w_in, w_hi, w_lo;
   logic                   w_closed_hi, w_closed_lo;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RELEASED;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // A control reversal inside the open window snaps back to the origin contact.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         RELEASED: if (bus.control) begin
            if (PULL_IN_CYCLES == 0) w_state_nxt = ENERGIZED;
            else begin
               w_state_nxt = PULLING;
               w_cnt_nxt   = PULL_LD;
            end
         end
         PULLING: begin
            if (!bus.control)        w_state_nxt = RELEASED;
            else if (r_cnt == 8'd1)  w_state_nxt = ENERGIZED;
            else                     w_cnt_nxt   = r_cnt - 8'd1;
         end
         ENERGIZED: if (!bus.control) begin
            if (DROP_OUT_CYCLES == 0) w_state_nxt = RELEASED;
            else begin
               w_state_nxt = DROPPING;
               w_cnt_nxt   = DROP_LD;
            end
         end
         DROPPING: begin
            if (bus.control)         w_state_nxt = ENERGIZED;
            else if (r_cnt == 8'd1)  w_state_nxt = RELEASED;
            else                     w_cnt_nxt   = r_cnt - 8'd1;
         end
         default: w_state_nxt = RELEASED;
      endcase
   end

   assign w_closed_hi   = (r_state == ENERGIZED);
   assign w_closed_lo   = (r_state == RELEASED);
   assign bus.energized = w_closed_hi;
   assign w_in          = {bus.in_3, bus.in_2, bus.in_1, bus.in_0};

   for (genvar g = 0; g < RELAY_POLES; g++) begin : g_pole
      relay_pole u_pole (
         .i_in        (w_in[g]),
         .i_closed_hi (w_closed_hi),
         .i_closed_lo (w_closed_lo),
         .o_out_hi    (w_hi[g]),
         .o_out_lo    (w_lo[g])
      );
   end

   assign {bus.out_hi_3, bus.out_hi_2, bus.out_hi_1, bus.out_hi_0} = w_hi;
   assign {bus.out_lo_3, bus.out_lo_2, bus.out_lo_1, bus.out_lo_0} = w_lo;
endmodule

// File: tb/tb_relay_4pdt.sv
// Bench for relay_4pdt: directed + random stimulus against a contact-position model, plus a zero-detect chain.
module tb_relay_4pdt;
   logic       clk;
   logic       rst;
   logic       ctl;
   logic [3:0] inv;
   logic [7:0] chain_v;
   int         n_pass, n_tot;

   relay_4pdt_if if_def ();
   relay_4pdt_if if_p3 ();
   relay_4pdt_if if_z ();
   relay_4pdt_if if_ch [8] ();

   relay_4pdt                                               u_def (.clk(clk), .reset(rst), .bus(if_def));
   relay_4pdt #(.PULL_IN_CYCLES(3), .DROP_OUT_CYCLES(2))    u_p3  (.clk(clk), .reset(rst), .bus(if_p3));
   relay_4pdt #(.PULL_IN_CYCLES(0), .DROP_OUT_CYCLES(0))    u_z   (.clk(clk), .reset(rst), .bus(if_z));

   assign if_def.control = ctl;
   assign if_p3.control  = ctl;
   assign if_z.control   = ctl;
   assign {if_def.in_3, if_def.in_2, if_def.in_1, if_def.in_0} = inv;
   assign {if_p3.in_3,  if_p3.in_2,  if_p3.in_1,  if_p3.in_0}  = inv;
   assign {if_z.in_3,   if_z.in_2,   if_z.in_1,   if_z.in_0}   = inv;

   for (genvar g = 0; g < 8; g++) begin : g_chain
      relay_4pdt u_ch (.clk(clk), .reset(rst), .bus(if_ch[g]));
      assign if_ch[g].control = chain_v[g];
      assign if_ch[g].in_0 = 1'b0;
      assign if_ch[g].in_1 = 1'b0;
      assign if_ch[g].in_2 = 1'b0;
      if (g == 0) begin : g_head
         assign if_ch[g].in_3 = 1'b1;
      end else begin : g_link
         assign if_ch[g].in_3 = if_ch[g-1].out_lo_3;
      end
   end

   logic chain_end;
   assign chain_end = if_ch[7].out_lo_3;

   // Observed {energized, hi[3:0], lo[3:0]} per single relay
   logic [8:0] obs_v [3];
   assign obs_v[0] = {if_def.energized, if_def.out_hi_3, if_def.out_hi_2, if_def.out_hi_1, if_def.out_hi_0,
                      if_def.out_lo_3, if_def.out_lo_2, if_def.out_lo_1, if_def.out_lo_0};
   assign obs_v[1] = {if_p3.energized, if_p3.out_hi_3, if_p3.out_hi_2, if_p3.out_hi_1, if_p3.out_hi_0,
                      if_p3.out_lo_3, if_p3.out_lo_2, if_p3.out_lo_1, if_p3.out_lo_0};
   assign obs_v[2] = {if_z.energized, if_z.out_hi_3, if_z.out_hi_2, if_z.out_hi_1, if_z.out_hi_0,
                      if_z.out_lo_3, if_z.out_lo_2, if_z.out_lo_1, if_z.out_lo_0};

   // Model: which side the armature is heading for, and how many edges of open gap remain.
   int m_pi [3] = '{1, 3, 0};
   int m_do [3] = '{1, 2, 0};
   bit m_hi  [3];
   int m_gap [3];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [8:0] model_out(input int k, input logic [3:0] v);
      bit hi_c, lo_c;
      hi_c = m_hi[k] && (m_gap[k] == 0);
      lo_c = !m_hi[k] && (m_gap[k] == 0);
      return {hi_c, hi_c ? v : 4'h0, lo_c ? v : 4'h0};
   endfunction

   function automatic void model_edge(input bit r, input bit c);
      for (int k = 0; k < 3; k++) begin
         if (r) begin
            m_hi[k] = 1'b0; m_gap[k] = 0;
         end else if (c != m_hi[k]) begin
            if (m_gap[k] > 0) m_gap[k] = 0;           // abort: back to where it came from
            else              m_gap[k] = c ? m_pi[k] : m_do[k];
            m_hi[k] = c;
         end else if (m_gap[k] > 0) begin
            m_gap[k]--;
         end
      end
   endfunction

   task automatic step(input bit r, input bit c, input logic [3:0] v);
      @(negedge clk);
      rst = r; ctl = c; inv = v;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("model[%0d]", k), {7'd0, obs_v[k]}, {7'd0, model_out(k, v)});
         chk($sformatf("bbm[%0d]", k), {12'd0, obs_v[k][7:4] & obs_v[k][3:0]}, 16'd0);
      end
      @(posedge clk);
      model_edge(r, c);
   endtask

   initial begin
      bit c;
      n_pass = 0; n_tot = 0;
      rst = 1'b1; ctl = 1'b1; inv = 4'b1000; chain_v = 8'h00;
      for (int k = 0; k < 3; k++) begin m_hi[k] = 1'b0; m_gap[k] = 0; end
      @(posedge clk);

      // Reset held with control high
      step(1, 1, 4'b1000);
      step(1, 1, 4'b1000);
      #1;
      chk("rst_lo3", {15'd0, if_def.out_lo_3}, 16'd1);
      chk("rst_hi3", {15'd0, if_def.out_hi_3}, 16'd0);
      chk("rst_en",  {15'd0, if_def.energized}, 16'd0);

      // Pull-in with defaults
      step(0, 1, 4'hF);
      #1; chk("pull_e1", {7'd0, obs_v[0]}, 16'h000);
      step(0, 1, 4'hF);
      #1; chk("pull_e2", {7'd0, obs_v[0]}, 16'h1F0);

      // Aborted pull-in on the 3-cycle relay
      repeat (4) step(0, 0, 4'hF);
      step(0, 1, 4'hA);
      #1; chk("abort_en1", {15'd0, if_p3.energized}, 16'd0);
      step(0, 1, 4'hA);
      #1; chk("abort_en2", {15'd0, if_p3.energized}, 16'd0);
      step(0, 0, 4'hA);
      #1; chk("abort_lo", {7'd0, obs_v[1]}, 16'h00A);

      // Zero-delay relay toggled each cycle
      for (int i = 0; i < 8; i++) begin
         step(0, i[0], 4'h1);
         #1; chk("zero_hl0", {14'd0, if_z.out_hi_0, if_z.out_lo_0}, i[0] ? 16'd2 : 16'd1);
      end

      // Random control/commons
      c = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 5) == 0) c = ~c;
         step($urandom_range(0, 999) == 0, c, 4'($urandom));
      end

      // Zero-detect chain
      @(negedge clk); rst = 1'b0; chain_v = 8'h00;
      repeat (3) @(posedge clk);
      #1; chk("chain_00", {15'd0, chain_end}, 16'd1);
      chain_v = 8'h80;
      @(posedge clk); #1; chk("chain_80_open", {15'd0, chain_end}, 16'd0);
      repeat (2) @(posedge clk);
      #1; chk("chain_80", {15'd0, chain_end}, 16'd0);
      chain_v = 8'h00;
      repeat (3) @(posedge clk);
      #1; chk("chain_00b", {15'd0, chain_end}, 16'd1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
